serial_link_arbiter: RTL and testbench

SERIAL_LINK_ARBITER -- requirements
Module: serial_link_arbiter

---
 rtl/serial_link_arbiter.sv | 175 +++++++++++++++++
 tb/tb_serial_link_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_arbiter.sv
// Round-robin arbiter that serialises one requester's word, LSB first, onto a
// single bit-serial link, then inserts a fixed number of idle gap cycles.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous active-low reset
//   req        per-requester request level, held until ack
//   data       flattened request words, requester i at [i*WORD_W +: WORD_W]
//   hold       downstream pause; freezes serialisation while high
//   ser_bit    serial data bit (forced to 0 when ser_valid is low)
//   ser_valid  qualifies ser_bit
//   grant      one-hot owner of the current transfer, zero otherwise
//   ack        one-cycle one-hot completion pulse
//   busy       high while shifting or in the gap
//   src_id     index of the granted requester; holds last value when idle
module serial_link_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WORD_W-1:0]  data,
    input  logic                       hold,
    output logic                       ser_bit,
    output logic                       ser_valid,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] src_id
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(WORD_W) + 1;
    localparam int unsigned GAP_W = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]         state_q,   state_d;
    logic [WORD_W-1:0]  sr_q,      sr_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [NUM_REQ-1:0] grant_q,   grant_d;
    logic [NUM_REQ-1:0] ack_q,     ack_d;
    logic [ID_W-1:0]    src_q,     src_d;
    logic [ID_W-1:0]    ptr_q,     ptr_d;
    logic               busy_q,    busy_d;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [WORD_W-1:0]  win_word;

    // Round-robin search starting at ptr_q; descending loop so the nearest hit wins.
    always_comb begin : arb
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(NUM_REQ)) begin
                idx = idx - int'(NUM_REQ);
            end
            if (req[ID_W'(idx)]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    // Word of the candidate winner.
    always_comb begin
        win_word = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win_idx == ID_W'(i)) begin
                win_word = data[i*WORD_W +: WORD_W];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        grant_d   = grant_q;
        ack_d     = '0;
        src_d     = src_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d   = SHIFT;
                    sr_d      = win_word;
                    bit_cnt_d = '0;
                    grant_d   = NUM_REQ'(1) << win_idx;
                    src_d     = win_idx;
                    ptr_d     = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
                    busy_d    = 1'b1;
                end
            end
            SHIFT: begin
                if (!hold) begin
                    sr_d      = sr_q >> 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                        grant_d = '0;
                        ack_d   = grant_q;
                        if (GAP_CYCLES != 0) begin
                            state_d   = GAP;
                            gap_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            GAP: begin
                // hold is deliberately ignored here: the gap never stretches.
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer without ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            src_q     <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            src_q     <= src_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
        end
    end

    // Serial outputs follow hold within the same cycle so a pause drops valid at once.
    assign ser_valid = (state_q == SHIFT) && !hold;
    assign ser_bit   = ser_valid & sr_q[0];

    assign grant  = grant_q;
    assign ack    = ack_q;
    assign busy   = busy_q;
    assign src_id = src_q;

endmodule

// File: tb/tb_serial_link_arbiter.sv
// Directed bench for serial_link_arbiter: one instance with a 1-cycle gap and
// one with no gap, plus a bit-serial receiver model on the first instance.
module tb_serial_link_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [3:0]   b_req;
    logic [127:0] data;
    logic         hold;

    logic         a_ser_bit, a_ser_valid, a_busy;
    logic [3:0]   a_grant, a_ack;
    logic [1:0]   a_src_id;
    logic         b_ser_bit, b_ser_valid, b_busy;
    logic [3:0]   b_grant, b_ack;
    logic [1:0]   b_src_id;

    int           vectors     = 0;
    int           miscompares = 0;

    logic [31:0]  rx      = 32'h0;
    int           vtotal  = 0;
    int           bad     = 0;
    int           ack_cnt [4] = '{0, 0, 0, 0};

    localparam logic [31:0] W0 = 32'hA5A5_0001;
    localparam logic [31:0] W1 = 32'h5A5A_0102;
    localparam logic [31:0] W2 = 32'h0F0F_F00F;
    localparam logic [31:0] W3 = 32'h8000_0001;

    always #5 clk = ~clk;

    serial_link_arbiter #(.NUM_REQ(4), .WORD_W(32), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .req(req), .data(data), .hold(hold),
        .ser_bit(a_ser_bit), .ser_valid(a_ser_valid), .grant(a_grant),
        .ack(a_ack), .busy(a_busy), .src_id(a_src_id)
    );

    serial_link_arbiter #(.NUM_REQ(4), .WORD_W(32), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .req(b_req), .data(data), .hold(hold),
        .ser_bit(b_ser_bit), .ser_valid(b_ser_valid), .grant(b_grant),
        .ack(b_ack), .busy(b_busy), .src_id(b_src_id)
    );

    // Receiver model: shifts in LSB first on each qualified edge.
    always @(posedge clk) begin
        if (a_ser_valid) begin
            rx     <= {a_ser_bit, rx[31:1]};
            vtotal <= vtotal + 1;
        end
        if ((hold && a_ser_valid) || (!a_ser_valid && a_ser_bit)) begin
            bad <= bad + 1;
        end
        for (int i = 0; i < 4; i++) begin
            if (a_ack[i]) ack_cnt[i] <= ack_cnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one transfer on dut_a until ack (bounded), then checks timing and data.
    task automatic run_a(input string tag, input logic [3:0] eg, input int egc,
                         input int eac, input logic [31:0] ew, input int hold_at,
                         input int hold_len, input int drop_at);
        int cyc;
        int gcyc;
        logic [3:0] gval;
        int v0;
        cyc  = 0;
        gcyc = 0;
        gval = 4'b0;
        v0   = vtotal;
        do begin
            @(negedge clk);
            cyc++;
            if (gcyc == 0 && a_grant != 4'b0) begin
                gcyc = cyc;
                gval = a_grant;
            end
            if (hold_at != 0 && cyc == hold_at) hold = 1'b1;
            if (hold_at != 0 && cyc == hold_at + hold_len) hold = 1'b0;
            if (drop_at != 0 && cyc == drop_at) begin
                req  = 4'b0;
                data = ~data;
            end
        end while (a_ack == 4'b0 && cyc < 200);
        chk({tag, " grant"},       32'(gval),       32'(eg));
        chk({tag, " grant_cycle"}, 32'(gcyc),       32'(egc));
        chk({tag, " ack_cycle"},   32'(cyc),        32'(eac));
        chk({tag, " ack"},         32'(a_ack),      32'(eg));
        chk({tag, " grant_clr"},   32'(a_grant),    32'h0);
        chk({tag, " busy_gap"},    32'(a_busy),     32'h1);
        chk({tag, " bits"},        32'(vtotal - v0), 32'd32);
        chk({tag, " word"},        rx,              ew);
    endtask

    initial begin
        int bc;
        reset = 1'b0;
        req   = 4'b0;
        b_req = 4'b0;
        data  = '0;
        hold  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst grant",     32'(a_grant),     32'h0);
        chk("rst ack",       32'(a_ack),       32'h0);
        chk("rst busy",      32'(a_busy),      32'h0);
        chk("rst ser_valid", 32'(a_ser_valid), 32'h0);
        chk("rst ser_bit",   32'(a_ser_bit),   32'h0);
        chk("rst src_id",    32'(a_src_id),    32'h0);

        // Single uncontended transfer from requester 1
        data[32 +: 32] = 32'hDEAD_BEEF;
        req   = 4'b0010;
        reset = 1'b1;
        run_a("t1", 4'b0010, 1, 33, 32'hDEAD_BEEF, 0, 0, 0);
        chk("t1 src_id", 32'(a_src_id), 32'h1);
        req = 4'b0;
        repeat (3) @(negedge clk);

        // Round robin with all requesting continuously, starting from reset
        reset = 1'b0;
        @(negedge clk);
        data  = {W3, W2, W1, W0};
        req   = 4'b1111;
        reset = 1'b1;
        run_a("rr0", 4'b0001, 1, 33, W0, 0, 0, 0);
        run_a("rr1", 4'b0010, 2, 34, W1, 0, 0, 0);
        run_a("rr2", 4'b0100, 2, 34, W2, 0, 0, 0);
        run_a("rr3", 4'b1000, 2, 34, W3, 0, 0, 0);
        run_a("rr4", 4'b0001, 2, 34, W0, 0, 0, 0);
        req = 4'b0;
        repeat (3) @(negedge clk);

        // Hold for 5 cycles after bit 10
        data[0 +: 32] = 32'h0000_0001;
        req = 4'b0001;
        run_a("hold", 4'b0001, 1, 38, 32'h0000_0001, 12, 5, 0);
        req = 4'b0;
        repeat (3) @(negedge clk);

        // Reset at bit 17 of requester 2
        data[64 +: 32] = 32'h0F0F_3C3C;
        req = 4'b0100;
        bc  = vtotal;
        repeat (18) @(negedge clk);
        chk("mid grant", 32'(a_grant), 32'h4);
        chk("mid bits",  32'(vtotal - bc), 32'd17);
        reset = 1'b0;
        #1;
        chk("async grant",     32'(a_grant),     32'h0);
        chk("async ack",       32'(a_ack),       32'h0);
        chk("async busy",      32'(a_busy),      32'h0);
        chk("async ser_valid", 32'(a_ser_valid), 32'h0);
        chk("async ser_bit",   32'(a_ser_bit),   32'h0);
        chk("async src_id",    32'(a_src_id),    32'h0);
        repeat (2) @(negedge clk);
        chk("abort no ack2", 32'(ack_cnt[2]), 32'd1);
        req   = 4'b0110;
        reset = 1'b1;
        run_a("rst_rr", 4'b0010, 1, 33, W1, 0, 0, 0);
        req = 4'b0;
        repeat (3) @(negedge clk);

        // Requester 0 drops req and changes data mid-transfer
        data[0 +: 32] = 32'hCAFE_F00D;
        req = 4'b0001;
        run_a("drop", 4'b0001, 1, 33, 32'hCAFE_F00D, 0, 0, 6);
        req = 4'b0;
        repeat (3) @(negedge clk);

        // No-gap instance: back-to-back with exactly one IDLE cycle
        data[0 +: 32] = 32'h1234_5678;
        b_req = 4'b0001;
        @(negedge clk);
        bc = 1;
        chk("b grant",     32'(b_grant),     32'h1);
        chk("b ser_valid", 32'(b_ser_valid), 32'h1);
        chk("b ser_bit0",  32'(b_ser_bit),   32'h0);
        while (b_ack == 4'b0 && bc < 200) begin
            @(negedge clk);
            bc++;
        end
        chk("b ack_cycle",      32'(bc),          32'd33);
        chk("b ack",            32'(b_ack),       32'h1);
        chk("b idle grant",     32'(b_grant),     32'h0);
        chk("b idle ser_valid", 32'(b_ser_valid), 32'h0);
        chk("b idle busy",      32'(b_busy),      32'h0);
        @(negedge clk);
        chk("b regrant",    32'(b_grant),     32'h1);
        chk("b re_valid",   32'(b_ser_valid), 32'h1);
        chk("b ack_pulse",  32'(b_ack),       32'h0);
        b_req = 4'b0;
        bc = 0;
        while (b_ack == 4'b0 && bc < 200) begin
            @(negedge clk);
            bc++;
        end
        chk("b second_ack", 32'(bc), 32'd32);
        repeat (2) @(negedge clk);

        // Whole-run invariants
        chk("valid_rules", 32'(bad), 32'h0);
        chk("ack_cnt0", 32'(ack_cnt[0]), 32'd4);
        chk("ack_cnt1", 32'(ack_cnt[1]), 32'd3);
        chk("ack_cnt2", 32'(ack_cnt[2]), 32'd1);
        chk("ack_cnt3", 32'(ack_cnt[3]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
